// File: rtl/obi_mux_2_to_1.sv
`default_nettype none
// ============================================================================
// Module   : obi_mux_2_to_1
// Two-master to one-slave OBI arbiter with a single outstanding transaction.
// Round-robin by default; define OBI_MUX_FIXED_PRIO_EN for master-0 priority.
// Revision : 1.0
// ============================================================================
module obi_mux_2_to_1 (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,

  output logic        owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state, w_state_next;
  logic   r_owner, w_owner_next;
`ifndef OBI_MUX_FIXED_PRIO_EN
  logic   r_last_gnt, w_last_gnt_next;
`endif
  logic   w_sel;
  logic   w_route;
  logic   w_route_req;

  // Selection is only free in IDLE; afterwards it is locked to the owner.
  always_comb begin
    w_sel = r_owner;
    if (r_state == IDLE) begin
      if (m0_req_i && m1_req_i) begin
`ifdef OBI_MUX_FIXED_PRIO_EN
        w_sel = 1'b0;
`else
        w_sel = ~r_last_gnt;
`endif
      end else begin
        w_sel = m1_req_i;
      end
    end
  end

  // Reset forces the payload mux onto master 0.
  assign w_route     = rst_ni & w_sel;
  assign w_route_req = w_route ? m1_req_i : m0_req_i;

  assign mem_addr_o  = w_route ? m1_addr_i  : m0_addr_i;
  assign mem_we_o    = w_route ? m1_we_i    : m0_we_i;
  assign mem_be_o    = w_route ? m1_be_i    : m0_be_i;
  assign mem_wdata_o = w_route ? m1_wdata_i : m0_wdata_i;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign owner_o     = rst_ni & r_owner;

  always_comb begin
    mem_req_o   = 1'b0;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    if (rst_ni) begin
      case (r_state)
        IDLE, ADDR: begin
          mem_req_o = w_route_req;
          m0_gnt_o  = mem_gnt_i & ~w_route;
          m1_gnt_o  = mem_gnt_i & w_route;
        end
        RESP: begin
          m0_rvalid_o = mem_rvalid_i & ~r_owner;
          m1_rvalid_o = mem_rvalid_i & r_owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
`ifndef OBI_MUX_FIXED_PRIO_EN
    w_last_gnt_next = r_last_gnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_route_req) begin
          w_owner_next = w_sel;
          if (mem_gnt_i) begin
            w_state_next    = RESP;
`ifndef OBI_MUX_FIXED_PRIO_EN
            w_last_gnt_next = w_sel;
`endif
          end else begin
            w_state_next = ADDR;
          end
        end
      end
      ADDR: begin
        // A retracted request abandons the locked selection.
        if (!w_route_req) begin
          w_state_next = IDLE;
        end else if (mem_gnt_i) begin
          w_state_next    = RESP;
`ifndef OBI_MUX_FIXED_PRIO_EN
          w_last_gnt_next = r_owner;
`endif
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
`ifndef OBI_MUX_FIXED_PRIO_EN
      r_last_gnt <= 1'b1;
`endif
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
`ifndef OBI_MUX_FIXED_PRIO_EN
      r_last_gnt <= w_last_gnt_next;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_mux_2_to_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_mux_2_to_1
// Directed and randomized bench for obi_mux_2_to_1 against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_obi_mux_2_to_1;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  obi_mux_2_to_1 dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .owner_o(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: master whose address phase is locked, queue of
  // masters awaiting a response, and the last master that was granted.
  int locked = -1;
  int pend_q[$];
  int last_w = 1;

  function automatic int pick(bit r0, bit r1);
    if (r0 && r1) begin
`ifdef OBI_MUX_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last_w;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  function automatic bit req_of(int m);
    return (m == 1) ? m1_req : m0_req;
  endfunction

  always @(posedge clk) begin : model_update
    int p;
    if (!rst_n) begin
      locked = -1;
      pend_q.delete();
      last_w = 1;
    end else if (pend_q.size() > 0) begin
      if (mem_rvalid) void'(pend_q.pop_front());
    end else if (locked >= 0) begin
      if (!req_of(locked)) locked = -1;
      else if (mem_gnt) begin
        pend_q.push_back(locked);
        last_w = locked;
        locked = -1;
      end
    end else begin
      p = pick(m0_req, m1_req);
      if (req_of(p)) begin
        if (mem_gnt) begin
          pend_q.push_back(p);
          last_w = p;
        end else begin
          locked = p;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int   rt;
    logic e_req, e_g0, e_g1, e_v0, e_v1, e_own;
    bit   own_chk, pay_chk;
    rt = 0; e_req = 0; e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_own = 0;
    own_chk = 0; pay_chk = 1;
    if (!rst_n) begin
      own_chk = 1;
    end else if (pend_q.size() > 0) begin
      own_chk = 1;
      pay_chk = 0;
      e_own   = (pend_q[0] == 1);
      if (pend_q[0] == 1) e_v1 = mem_rvalid;
      else                e_v0 = mem_rvalid;
    end else begin
      if (locked >= 0) begin
        rt      = locked;
        own_chk = 1;
        e_own   = (locked == 1);
      end else begin
        rt = pick(m0_req, m1_req);
      end
      e_req = req_of(rt);
      e_g0  = (rt == 0) & mem_gnt;
      e_g1  = (rt == 1) & mem_gnt;
    end
    chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, e_g0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, e_g1});
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, e_v0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e_v1});
    chk("m0_rdata", m0_rdata, mem_rdata);
    chk("m1_rdata", m1_rdata, mem_rdata);
    if (own_chk) chk("owner", {31'd0, owner}, {31'd0, e_own});
    if (pay_chk) begin
      chk("mem_addr", mem_addr, (rt == 1) ? m1_addr : m0_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, (rt == 1) ? m1_we : m0_we});
      chk("mem_be", {28'd0, mem_be}, {28'd0, (rt == 1) ? m1_be : m0_be});
      chk("mem_wdata", mem_wdata, (rt == 1) ? m1_wdata : m0_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    m0_req = 0; m1_req = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  int exp_w[4];
  int winner;

  initial begin
    rst_n = 0; set_idle();
    m0_addr = 0; m1_addr = 0; m0_we = 0; m1_we = 0; m0_be = 0; m1_be = 0;
    m0_wdata = 0; m1_wdata = 0; mem_rdata = 0;
`ifdef OBI_MUX_FIXED_PRIO_EN
    exp_w = '{0, 0, 0, 0};
`else
    exp_w = '{0, 1, 0, 1};
`endif
    cyc();
    @(negedge clk);
    chk("lit_reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("lit_reset_owner", {31'd0, owner}, 32'd0);
    cyc();
    rst_n = 1;

    // Single read by master 0
    m0_req = 1; m0_addr = 32'h0000_1004; mem_gnt = 1;
    @(negedge clk);
    chk("lit_read_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("lit_read_addr", mem_addr, 32'h0000_1004);
    cyc();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("lit_read_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("lit_read_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("lit_read_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    cyc();
    set_idle();
    cyc();

    // Grant stall on master 1 while master 0 waits
    m1_req = 1; m1_addr = 32'h0000_2000; m0_addr = 32'h0000_3000;
    @(negedge clk);
    chk("lit_stall_addr0", mem_addr, 32'h0000_2000);
    cyc();
    m0_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lit_stall_addr", mem_addr, 32'h0000_2000);
      chk("lit_stall_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("lit_stall_owner", {31'd0, owner}, 32'd1);
      cyc();
    end
    mem_gnt = 1;
    @(negedge clk);
    chk("lit_stall_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("lit_stall_m0_gnt3", {31'd0, m0_gnt}, 32'd0);
    cyc();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("lit_stall_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    cyc();
    mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    chk("lit_stall_m0_served", {31'd0, m0_gnt}, 32'd1);
    chk("lit_stall_m0_addr", mem_addr, 32'h0000_3000);
    cyc();
    m0_req = 0; mem_gnt = 0; mem_rvalid = 1;
    cyc();
    set_idle();
    cyc();

    // Blocking while a response is outstanding
    m0_req = 1; mem_gnt = 1;
    cyc();
    m0_req = 0; mem_gnt = 0; m1_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_block_mem_req", {31'd0, mem_req}, 32'd0);
      chk("lit_block_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      cyc();
    end
    mem_rvalid = 1;
    @(negedge clk);
    chk("lit_block_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("lit_block_mem_req_rv", {31'd0, mem_req}, 32'd0);
    cyc();
    mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    chk("lit_block_m1_gnt_after", {31'd0, m1_gnt}, 32'd1);
    cyc();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1;
    cyc();
    set_idle();
    cyc();

    // Spurious response in IDLE
    mem_rvalid = 1;
    @(negedge clk);
    chk("lit_spur_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("lit_spur_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    cyc();
    mem_rvalid = 0; m1_req = 1;
    @(negedge clk);
    chk("lit_spur_idle_req", {31'd0, mem_req}, 32'd1);
    cyc();
    mem_gnt = 1;
    cyc();
    m1_req = 0; mem_gnt = 0; mem_rvalid = 1;
    cyc();
    set_idle();
    cyc();

    // Reset while in RESP, late rvalid, then contention
    m0_req = 1; mem_gnt = 1;
    cyc();
    m0_req = 0; mem_gnt = 0; rst_n = 0;
    @(negedge clk);
    chk("lit_rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    cyc();
    rst_n = 1; mem_rvalid = 1;
    @(negedge clk);
    chk("lit_rst_late_rvalid", {31'd0, m0_rvalid}, 32'd0);
    cyc();
    mem_rvalid = 0;
    m0_req = 1; m1_req = 1;
    for (int k = 0; k < 4; k++) begin
      mem_gnt = 1; mem_rvalid = 0;
      @(negedge clk);
      winner = m1_gnt ? 1 : 0;
      chk("lit_contend_winner", winner, exp_w[k]);
      chk("lit_contend_onehot", {30'd0, m1_gnt, m0_gnt}, (exp_w[k] == 1) ? 32'd2 : 32'd1);
      cyc();
      mem_gnt = 0; mem_rvalid = 1;
      cyc();
    end
    set_idle();
    cyc();

    // Randomized traffic, including retractions, spurious rvalid and resets
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      m0_req     = $urandom_range(0, 1);
      m1_req     = $urandom_range(0, 1);
      m0_addr    = $urandom;  m1_addr  = $urandom;
      m0_wdata   = $urandom;  m1_wdata = $urandom;
      m0_we      = $urandom_range(0, 1);
      m1_we      = $urandom_range(0, 1);
      m0_be      = 4'($urandom_range(0, 15));
      m1_be      = 4'($urandom_range(0, 15));
      mem_gnt    = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      cyc();
    end
    rst_n = 1;
    set_idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_mux_2_to_1.md
# obi_mux_2_to_1

Two-master to one-slave OBI arbiter that sits directly upstream of the address-decoding OBI demux. It merges two OBI controllers, typically a core's instruction and data ports, onto the single controller port the demux consumes. It allows at most one outstanding transaction at a time, which matches the demux's single-outstanding limit. Arbitration is round-robin by default, or fixed priority when configured (see Configuration). The response is routed back to the master that owns the transaction.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- m0_req_i  in  1  master 0 request
- m0_gnt_o  out  1  master 0 grant
- m0_addr_i  in  32  master 0 address
- m0_we_i  in  1  master 0 write enable
- m0_be_i  in  4  master 0 byte enables
- m0_wdata_i  in  32  master 0 write data
- m0_rvalid_o  out  1  master 0 response valid
- m0_rdata_o  out  32  master 0 read data
- m1_req_i, m1_gnt_o, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_rvalid_o, m1_rdata_o: same directions, widths and meanings, for master 1
- mem_req_o  out  1  request to downstream demux
- mem_gnt_i  in  1  grant from downstream
- mem_addr_o  out  32  routed address
- mem_we_o  out  1  routed write enable
- mem_be_o  out  4  routed byte enables
- mem_wdata_o  out  32  routed write data
- mem_rvalid_i  in  1  downstream response valid
- mem_rdata_i  in  32  downstream read data
- owner_o  out  1  index of the master owning the current transaction; valid in ADDR and RESP

## Operation
- FSM states:
  - IDLE: no transaction active.
  - ADDR: a request has been presented but not yet granted; the selection is locked.
  - RESP: the request was granted and the block is waiting for rvalid.
- IDLE:
  - sel is computed combinationally from the requests.
  - If only one master requests, sel is that master.
  - If both request, sel = !last_gnt (round-robin).
  - mem_req_o = req of sel. mem_addr/we/be/wdata come from sel.
  - m<sel>_gnt_o = mem_gnt_i. The other master's gnt is 0.
  - Requesting and granted in the same cycle: go to RESP, owner <= sel, last_gnt <= sel.
  - Requesting and not granted: go to ADDR, owner <= sel.
- ADDR:
  - Route only the owner: mem_req_o = m<owner>_req_i, payload from the owner, m<owner>_gnt_o = mem_gnt_i.
  - The non-owner's gnt is 0, even if it requests.
  - On mem_gnt_i: go to RESP, last_gnt <= owner.
  - OBI forbids retracting req before gnt. If the owner's req drops anyway, go back to IDLE.
- RESP:
  - mem_req_o = 0 and both gnt outputs are 0.
  - m<owner>_rvalid_o = mem_rvalid_i.
  - On mem_rvalid_i: go to IDLE.
- Response routing:
  - Non-owner rvalid is always 0.
  - m0_rdata_o and m1_rdata_o both equal mem_rdata_i unconditionally. Masters qualify the data with rvalid.
- mem_rvalid_i in IDLE or ADDR is spurious: it is ignored and not forwarded.
- Writes also complete through the RESP state, because OBI returns rvalid for writes.

## Timing
- Address phase is zero-latency: the path from m*_req_i to mem_req_o and from mem_gnt_i to m*_gnt_o is purely combinational.
- Response is pass-through in the same cycle: mem_rvalid_i to m<owner>_rvalid_o is combinational.
- Throughput: at most one transaction per two cycles. A new request is accepted no earlier than the cycle after rvalid.
- Reset (rst_ni low at a clock edge):
  - state <= IDLE, owner <= 0, last_gnt <= 1 (so master 0 wins the first contention).
- While rst_ni is low, outputs are gated combinationally:
  - mem_req_o = 0, m0_gnt_o = m1_gnt_o = 0, m0_rvalid_o = m1_rvalid_o = 0, owner_o = 0.
  - Payload outputs follow master 0.
- Reset mid-transaction abandons the transaction. A late mem_rvalid_i that arrives after reset, while in IDLE, is dropped.

## Configuration
- OBI_MUX_FIXED_PRIO_EN:
  - Defined: when both masters request in IDLE, master 0 always wins; last_gnt is unused.
  - Undefined (default): round-robin as described above.
- FSM and response routing are identical in both builds.

## Test plan
- Single read: m0 requests addr 0x00001004, mem_gnt_i=1 in the same cycle, rvalid one cycle later with 0x12345678.
  - m0_gnt_o=1 in cycle 0.
  - m0_rvalid_o=1, m0_rdata_o=0x12345678 in cycle 1.
  - m1_rvalid_o=0 throughout.
- Contention: m0 and m1 both request continuously, each transaction granted at once with rvalid next cycle.
  - Default build: grants alternate m0, m1, m0, m1.
  - OBI_MUX_FIXED_PRIO_EN build: all four grants go to m0.
- Grant stall: m1 requests with mem_gnt_i=0 for 3 cycles, and m0 raises req in cycle 1.
  - mem_addr_o stays at m1's address and m0_gnt_o=0 until m1 is granted in cycle 3.
  - m0 is serviced after m1's rvalid.
- Blocking while outstanding: m0 is granted, rvalid is delayed 5 cycles, m1 requests meanwhile.
  - mem_req_o=0 until rvalid.
  - m1 is granted the cycle after rvalid.
- Spurious response: mem_rvalid_i=1 pulse while in IDLE.
  - Both m*_rvalid_o stay 0 and the state is unchanged.
- Reset mid-op: rst_ni low for 1 cycle while in RESP.
  - Returns to IDLE.
  - A subsequent mem_rvalid_i is not forwarded.
  - The next contention is won by m0.
